// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - pulse-train high-time and period capture with valid/ack handshake
//
// Samples PWM_IN through a 2-flop synchronizer and an optional glitch filter.
// The filter is compiled in when PWM_CAPTURE_FILTER_EN is defined. The block
// measures high time and rising-to-rising period in SYSCLK cycles, inclusive
// of the edge cycle, and holds each result until ACK.
//
// Parameters:
//   CNT_W      width of the counters and results
//   FILT_LEN   consecutive differing samples needed to flip the filtered level
//              (2..15, used only with PWM_CAPTURE_FILTER_EN)
// Ports:
//   SYSCLK      fabric clock, rising edge
//   NSYSRESET   asynchronous active-low reset
//   PWM_IN      asynchronous pulse input
//   EN          capture enable; low forces IDLE and drops partial counts
//   ACK         one-cycle pulse; consumes the result and clears sticky flags
//   HIGH_CNT    latched high time
//   PERIOD_CNT  latched period
//   VALID       result available
//   OVERRUN     sticky: a result was dropped while VALID was high
//   TIMEOUT     sticky: a counter saturated before the next edge
module pwm_capture #(
    parameter int CNT_W    = 24,
    parameter int FILT_LEN = 4
) (
    input  logic             SYSCLK,
    input  logic             NSYSRESET,
    input  logic             PWM_IN,
    input  logic             EN,
    input  logic             ACK,
    output logic [CNT_W-1:0] HIGH_CNT,
    output logic [CNT_W-1:0] PERIOD_CNT,
    output logic             VALID,
    output logic             OVERRUN,
    output logic             TIMEOUT
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Marker block: FILT_LEN outside 2..15 shows up in the elaborated hierarchy.
    if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_filt_len_out_of_range
    end

    logic [1:0] sync;
    logic       lvl;
    logic       lvl_d;
    logic       rise;
    logic       fall;

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], PWM_IN};
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

    logic [3:0] filt_cnt;
    logic       filt_lvl;

    // Counts consecutive samples that disagree with the filtered level; any
    // agreeing sample restarts the run, so short pulses never get through.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            filt_cnt <= 4'd0;
            filt_lvl <= 1'b0;
        end else if (sync[1] != filt_lvl) begin
            if (filt_cnt == FILT_LAST) begin
                filt_lvl <= sync[1];
                filt_cnt <= 4'd0;
            end else begin
                filt_cnt <= filt_cnt + 4'd1;
            end
        end else begin
            filt_cnt <= 4'd0;
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = sync[1];
`endif

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    logic [1:0]       state;
    logic [CNT_W-1:0] high_acc;
    logic [CNT_W-1:0] period_acc;
    logic             measuring;
    logic             sat;
    logic             latch;
    logic             timeout_evt;

    // Saturation takes priority over an edge in the same cycle: the true count
    // would no longer fit, so the measurement is abandoned.
    assign measuring   = EN && (state == ST_HIGH || state == ST_LOW);
    assign sat         = (high_acc == CNT_MAX) || (period_acc == CNT_MAX);
    assign timeout_evt = measuring && sat;
    assign latch       = EN && (state == ST_LOW) && rise && !sat;

    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state      <= ST_IDLE;
            high_acc   <= '0;
            period_acc <= '0;
        end else if (!EN) begin
            state      <= ST_IDLE;
            high_acc   <= '0;
            period_acc <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state      <= ST_ARM;
                    high_acc   <= '0;
                    period_acc <= '0;
                end
                ST_ARM: begin
                    if (rise) begin
                        state      <= ST_HIGH;
                        high_acc   <= CNT_ONE;
                        period_acc <= CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (sat) begin
                        state      <= ST_ARM;
                        high_acc   <= '0;
                        period_acc <= '0;
                    end else if (fall) begin
                        state      <= ST_LOW;
                        period_acc <= period_acc + CNT_ONE;
                    end else begin
                        high_acc   <= high_acc + CNT_ONE;
                        period_acc <= period_acc + CNT_ONE;
                    end
                end
                default: begin
                    if (sat) begin
                        state      <= ST_ARM;
                        high_acc   <= '0;
                        period_acc <= '0;
                    end else if (rise) begin
                        state      <= ST_HIGH;
                        high_acc   <= CNT_ONE;
                        period_acc <= CNT_ONE;
                    end else begin
                        period_acc <= period_acc + CNT_ONE;
                    end
                end
            endcase
        end
    end

    // A latch with ACK in the same cycle replaces the result and keeps VALID;
    // a latch against an unacknowledged result is dropped and flagged.
    always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            HIGH_CNT   <= '0;
            PERIOD_CNT <= '0;
            VALID      <= 1'b0;
            OVERRUN    <= 1'b0;
            TIMEOUT    <= 1'b0;
        end else begin
            if (latch) begin
                if (!VALID || ACK) begin
                    HIGH_CNT   <= high_acc;
                    PERIOD_CNT <= period_acc;
                    VALID      <= 1'b1;
                end
            end else if (ACK) begin
                VALID <= 1'b0;
            end

            if (latch && VALID && !ACK) begin
                OVERRUN <= 1'b1;
            end else if (ACK) begin
                OVERRUN <= 1'b0;
            end

            if (timeout_evt) begin
                TIMEOUT <= 1'b1;
            end else if (ACK) begin
                TIMEOUT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

    localparam int CNT_W    = 8;
    localparam int FILT_LEN = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT  = FILT_LEN + 3;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FILT = 1'b0;
`endif

    logic             SYSCLK;
    logic             NSYSRESET;
    logic             PWM_IN;
    logic             EN;
    logic             ACK;
    logic [CNT_W-1:0] HIGH_CNT;
    logic [CNT_W-1:0] PERIOD_CNT;
    logic             VALID;
    logic             OVERRUN;
    logic             TIMEOUT;

    int ncmp  = 0;
    int nfail = 0;

    pwm_capture #(
        .CNT_W    (CNT_W),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .SYSCLK     (SYSCLK),
        .NSYSRESET  (NSYSRESET),
        .PWM_IN     (PWM_IN),
        .EN         (EN),
        .ACK        (ACK),
        .HIGH_CNT   (HIGH_CNT),
        .PERIOD_CNT (PERIOD_CNT),
        .VALID      (VALID),
        .OVERRUN    (OVERRUN),
        .TIMEOUT    (TIMEOUT)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    task automatic cyc();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int v, input int o, input int t);
        chk({tag, "_valid"},   32'(VALID),   v);
        chk({tag, "_overrun"}, 32'(OVERRUN), o);
        chk({tag, "_timeout"}, 32'(TIMEOUT), t);
    endtask

    task automatic chk_res(input string tag, input int h, input int p);
        chk({tag, "_high"},   32'(HIGH_CNT),   h);
        chk({tag, "_period"}, 32'(PERIOD_CNT), p);
    endtask

    task automatic ack_pulse();
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;
    endtask

    task automatic hi_lo(input int h, input int l);
        PWM_IN = 1'b1;
        repeat (h) cyc();
        PWM_IN = 1'b0;
        repeat (l) cyc();
    endtask

    // Drives one period whose rise closes the previous one; checks VALID is
    // still low one edge before the expected latency and the result at it.
    task automatic hi_lo_latch(input string tag, input int h, input int l,
                               input int eh, input int ep);
        PWM_IN = 1'b1;
        repeat (LAT - 1) cyc();
        chk({tag, "_pre_valid"}, 32'(VALID), 0);
        cyc();
        chk({tag, "_valid"}, 32'(VALID), 1);
        chk_res(tag, eh, ep);
        repeat (h - LAT) cyc();
        PWM_IN = 1'b0;
        repeat (l) cyc();
    endtask

    initial begin
        PWM_IN    = 1'b0;
        EN        = 1'b0;
        ACK       = 1'b0;
        NSYSRESET = 1'b0;
        repeat (3) cyc();
        chk_flags("reset", 0, 0, 0);
        chk_res("reset", 0, 0);
        NSYSRESET = 1'b1;
        cyc();
        EN = 1'b1;
        repeat (10) cyc();

        // 30/100 square wave: first rise yields nothing, next two rises latch.
        hi_lo(30, 70);
        chk("first_rise_no_valid", 32'(VALID), 0);
        hi_lo_latch("sq1", 30, 69, 30, 100);
        ack_pulse();
        chk("sq1_ack_valid", 32'(VALID), 0);
        hi_lo_latch("sq2", 30, 69, 30, 100);
        ack_pulse();
        chk("sq2_ack_valid", 32'(VALID), 0);

        // 2-cycle high glitch 20 cycles into a 70-cycle low.
        hi_lo_latch("gl_open", 30, 19, 30, 100);
        ack_pulse();
        chk("gl_open_ack_valid", 32'(VALID), 0);
        PWM_IN = 1'b1;
        repeat (2) cyc();
        PWM_IN = 1'b0;
        repeat (10) cyc();
        chk("gl_mid_valid", 32'(VALID), FILT ? 0 : 1);
        chk_res("gl_mid", 30, FILT ? 100 : 50);
        ack_pulse();
        repeat (37) cyc();
        hi_lo_latch("gl_close", 30, 69, FILT ? 30 : 2, FILT ? 100 : 50);
        ack_pulse();
        chk("gl_close_ack_valid", 32'(VALID), 0);

        // Overrun: 30/100 held, following 40/90 dropped.
        PWM_IN = 1'b1;
        repeat (LAT) cyc();
        chk_flags("ov_first", 1, 0, 0);
        chk_res("ov_first", 30, 100);
        repeat (40 - LAT) cyc();
        PWM_IN = 1'b0;
        repeat (50) cyc();
        PWM_IN = 1'b1;
        repeat (LAT) cyc();
        chk_flags("ov_drop", 1, 1, 0);
        chk_res("ov_drop", 30, 100);
        ack_pulse();
        chk_flags("ov_ack", 0, 0, 0);
        repeat (20 - LAT - 1) cyc();
        PWM_IN = 1'b0;
        repeat (40) cyc();

        // 20/60 latched into an empty slot, then 25/80 latched with ACK on the same edge.
        PWM_IN = 1'b1;
        repeat (LAT) cyc();
        chk("p2060_valid", 32'(VALID), 1);
        chk_res("p2060", 20, 60);
        repeat (25 - LAT) cyc();
        PWM_IN = 1'b0;
        repeat (55) cyc();
        PWM_IN = 1'b1;
        repeat (LAT - 1) cyc();
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        chk_flags("sim_ack", 1, 0, 0);
        chk_res("sim_ack", 25, 80);

        // Held high after that rise: period counter saturates at 255.
        ack_pulse();
        chk("to_ack_valid", 32'(VALID), 0);
        repeat (253) cyc();
        chk("to_before", 32'(TIMEOUT), 0);
        cyc();
        chk("to_set", 32'(TIMEOUT), 1);
        repeat (20) cyc();
        chk_flags("to_hold", 0, 0, 1);
        ack_pulse();
        chk("to_ack_clear", 32'(TIMEOUT), 0);
        PWM_IN = 1'b0;
        repeat (30) cyc();
        hi_lo(20, 30);
        chk("to_first_rise", 32'(VALID), 0);
        hi_lo_latch("to_recov", 20, 29, 20, 50);
        ack_pulse();
        chk("to_recov_ack", 32'(VALID), 0);

        // EN dropped 10 cycles into HIGH.
        PWM_IN = 1'b1;
        repeat (LAT) cyc();
        chk("ab_latch_valid", 32'(VALID), 1);
        chk_res("ab_latch", 20, 50);
        ack_pulse();
        repeat (9) cyc();
        EN = 1'b0;
        cyc();
        EN = 1'b1;
        cyc();
        chk("ab_en_valid", 32'(VALID), 0);
        chk_res("ab_en", 20, 50);
        repeat (20) cyc();
        PWM_IN = 1'b0;
        repeat (70) cyc();
        hi_lo(30, 70);
        chk("ab_no_result", 32'(VALID), 0);
        hi_lo_latch("ab_next", 30, 40, 30, 100);

        // Asynchronous reset mid-LOW with VALID set.
        #2;
        NSYSRESET = 1'b0;
        #1;
        chk_flags("rst_mid", 0, 0, 0);
        chk_res("rst_mid", 0, 0);
        repeat (2) cyc();
        NSYSRESET = 1'b1;
        cyc();
        hi_lo(30, 70);
        chk("rst_first_rise", 32'(VALID), 0);
        hi_lo_latch("rst_resume", 30, 69, 30, 100);
        ack_pulse();
        chk_flags("rst_resume_ack", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
